// File: rtl/riscv_boot_ctrl.sv
// rtl/riscv_boot_ctrl.sv - streamed memory loader and reset/run supervisor for the RISC-V core
// Loads N_REGIONS memories from a valid/ready stream, then holds, runs and watches the core.
module riscv_boot_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int N_REGIONS  = 2,
  parameter int RST_HOLD   = 10,
  parameter int RUN_CYCLES = 10000,
  localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                 clk,
  input  logic                 Rstn,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [RW-1:0]        ld_region,
  input  logic                 ld_last,
  output logic [N_REGIONS-1:0] mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 core_rstn,
  input  logic                 halt_i,
  input  logic                 restart_i,
  output logic [31:0]          run_cnt,
  output logic                 done,
  output logic                 timeout,
  output logic                 err_ovf
);

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr [N_REGIONS];
  logic [N_REGIONS-1:0] full;
  logic [N_REGIONS-1:0] sel_oh;
  logic [N_REGIONS-1:0] wr_oh;
  logic [ADDR_W-1:0]    cur_addr;
  logic [31:0]          hold_cnt;
  logic                 beat;
  logic                 hold_done;
  logic                 run_limit;

  // An out-of-range region index matches no entry, so it falls into the drop path.
  always_comb begin
    sel_oh   = '0;
    cur_addr = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (ld_region == RW'(r)) begin
        sel_oh[r] = 1'b1;
        cur_addr  = addr[r];
      end
    end
    wr_oh = sel_oh & ~full;
  end

  assign beat      = ld_valid & ld_ready;
  assign hold_done = (hold_cnt == 32'(RST_HOLD - 1));
  assign run_limit = (run_cnt == 32'(RUN_CYCLES));

  always_ff @(posedge clk or negedge Rstn) begin
    if (!Rstn) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = S_HOLD;
      end
      S_HOLD: if (hold_done) state_d = S_RUN;
      S_RUN:  if (halt_i || run_limit) state_d = S_DONE;
      S_DONE: if (restart_i) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge Rstn) begin
    if (!Rstn) begin
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rstn <= 1'b0;
      run_cnt   <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_ovf   <= 1'b0;
      hold_cnt  <= '0;
      full      <= '0;
      for (int r = 0; r < N_REGIONS; r++) addr[r] <= '0;
    end else begin
      mem_we <= '0;
      case (state_q)
        S_LOAD: begin
          hold_cnt <= '0;
          if (beat) begin
            if (|wr_oh) begin
              mem_we    <= wr_oh;
              mem_addr  <= cur_addr;
              mem_wdata <= ld_data;
            end else begin
              err_ovf <= 1'b1;
            end
            // The counter parks on its last address; the full flag marks it used.
            for (int r = 0; r < N_REGIONS; r++) begin
              if (wr_oh[r]) begin
                if (&addr[r]) full[r] <= 1'b1;
                else          addr[r] <= addr[r] + 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + 32'd1;
          if (hold_done) begin
            core_rstn <= 1'b1;
            run_cnt   <= 32'd1;
          end
        end
        S_RUN: begin
          if (halt_i || run_limit) begin
            core_rstn <= 1'b0;
            done      <= 1'b1;
            timeout   <= ~halt_i;
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        S_DONE: begin
          if (restart_i) begin
            run_cnt <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            err_ovf <= 1'b0;
            full    <= '0;
            for (int r = 0; r < N_REGIONS; r++) addr[r] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
